// File: rtl/bound_flasher_monitor.sv
// Passive checker/decoder for the bound flasher LED bus: decodes level, direction
// and sequence phase, and accumulates sticky protocol error flags.
module bound_flasher_monitor #(
    parameter int unsigned MAX_HOLD   = 3,
    parameter int unsigned ARM_WINDOW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] leds,
    input  logic        flick,
    input  logic        clr_err,
    output logic [4:0]  level,
    output logic [1:0]  dir,
    output logic [2:0]  phase,
    output logic        kickback,
    output logic        seq_done,
    output logic [4:0]  err_flags
);

    localparam int unsigned LVL_W  = 5;
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 2);
    localparam int unsigned TMR_W  = $clog2(ARM_WINDOW + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [LVL_W-1:0]    level_q, peak_q, peak_d;
    logic [1:0]          dir_q, dir_d;
    logic                kick_q, kick_d, done_q, done_d;
    logic [4:0]          err_q, err_d, new_err;
    logic                armed_q, armed_d, seen_q, seen_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [LVL_W-1:0]    lvl_c;
    logic [16:0]         mask_c;
    logic                thermo_bad_c, up_c, dn_c, same_c, low_c, kick_c;

    // Popcount and the thermometer pattern that popcount implies.
    always_comb begin
        lvl_c = '0;
        for (int i = 0; i < 16; i++) begin
            lvl_c = lvl_c + LVL_W'(leds[i]);
        end
        mask_c = (17'd1 << lvl_c) - 17'd1;
    end

    assign thermo_bad_c = {1'b0, leds} != mask_c;
    assign up_c   = (6'(lvl_c) == 6'(level_q) + 6'd1);
    assign dn_c   = (6'(lvl_c) + 6'd1 == 6'(level_q));
    assign same_c = (lvl_c == level_q);
    assign low_c  = (lvl_c <= 5'd5);
    assign kick_c = seen_q | (flick & low_c);

    always_comb begin
        phase_d = phase_q;
        peak_d  = peak_q;
        dir_d   = dir_q;
        kick_d  = 1'b0;
        done_d  = 1'b0;
        armed_d = armed_q;
        tmr_d   = tmr_q;
        hold_d  = hold_q;
        seen_d  = seen_q;
        new_err = '0;

        new_err[0] = thermo_bad_c;

        // Direction only updates on legal unit steps; a jump keeps the old value.
        if (up_c)        dir_d = 2'b01;
        else if (dn_c)   dir_d = 2'b10;
        else if (same_c) dir_d = 2'b00;
        else             new_err[1] = 1'b1;

        if (!same_c) begin
            hold_d = '0;
        end else if (hold_q <= HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        if (same_c && hold_q == HOLD_W'(MAX_HOLD) && phase_q != IDLE) begin
            new_err[4] = 1'b1;
        end

        if (phase_q == IDLE && flick) begin
            armed_d = 1'b1;
            tmr_d   = TMR_W'(ARM_WINDOW);
        end else if (armed_q) begin
            if (tmr_q == '0) armed_d = 1'b0;
            else             tmr_d   = tmr_q - TMR_W'(1);
        end

        if ((phase_q == DN1 || phase_q == DN2) && flick && low_c) begin
            seen_d = 1'b1;
        end

        case (phase_q)
            IDLE: begin
                if (up_c && lvl_c == 5'd1) begin
                    if (!(armed_q || flick)) new_err[3] = 1'b1;
                    phase_d = UP1;
                    peak_d  = 5'd16;
                    armed_d = 1'b0;
                end
            end
            UP1, UP2, UP3: begin
                if (dn_c) begin
                    if (level_q != peak_q) new_err[2] = 1'b1;
                    phase_d = (phase_q == UP1) ? DN1 : (phase_q == UP2) ? DN2 : DN3;
                end
            end
            DN1: begin
                if (up_c) begin
                    if (level_q != 5'd5) new_err[2] = 1'b1;
                    if (kick_c) begin
                        phase_d = UP1;
                        peak_d  = 5'd16;
                        kick_d  = 1'b1;
                    end else begin
                        phase_d = UP2;
                        peak_d  = 5'd11;
                    end
                end
            end
            DN2: begin
                if (up_c) begin
                    if (level_q != 5'd0) new_err[2] = 1'b1;
                    if (kick_c) begin
                        phase_d = UP2;
                        peak_d  = 5'd11;
                        kick_d  = 1'b1;
                    end else begin
                        phase_d = UP3;
                        peak_d  = 5'd6;
                    end
                end
            end
            DN3: begin
                if (up_c) begin
                    new_err[2] = 1'b1;
                end else if (dn_c && lvl_c == 5'd0) begin
                    phase_d = IDLE;
                    done_d  = 1'b1;
                    armed_d = 1'b0;
                end
            end
            default: phase_d = IDLE;
        endcase

        // Flick history is per phase visit.
        if (phase_d != phase_q) seen_d = 1'b0;

        // A fresh error in the clearing cycle survives the clear.
        err_d = (clr_err ? 5'd0 : err_q) | new_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= IDLE;
            level_q <= '0;
            peak_q  <= 5'd16;
            dir_q   <= 2'b00;
            kick_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            armed_q <= 1'b0;
            tmr_q   <= '0;
            hold_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            level_q <= lvl_c;
            peak_q  <= peak_d;
            dir_q   <= dir_d;
            kick_q  <= kick_d;
            done_q  <= done_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            tmr_q   <= tmr_d;
            hold_q  <= hold_d;
            seen_q  <= seen_d;
        end
    end

    assign level     = level_q;
    assign dir       = dir_q;
    assign phase     = phase_q;
    assign kickback  = kick_q;
    assign seq_done  = done_q;
    assign err_flags = err_q;

endmodule
